// File: rtl/sdram_wb_arbiter.sv
// Wishbone classic arbiter in front of sdram_ctrl_wb: master 0 has fixed priority,
// masters 1..N-1 share round-robin, and every grant is capped at MAX_BURST acks.
module sdram_wb_arbiter #(
    parameter int NUM_MASTERS   = 3,
    parameter int WB_ADDR_WIDTH = 24,
    parameter int WB_DATA_WIDTH = 16,
    parameter int MAX_BURST     = 8
) (
    input  logic                                       wb_clk_i,
    input  logic                                       wb_rst_i,
    input  logic [NUM_MASTERS-1:0]                     m_cyc_i,
    input  logic [NUM_MASTERS-1:0]                     m_stb_i,
    input  logic [NUM_MASTERS-1:0]                     m_we_i,
    input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0]       m_adr_i,
    input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]       m_dat_i,
    input  logic [NUM_MASTERS*(WB_DATA_WIDTH/8)-1:0]   m_sel_i,
    output logic [NUM_MASTERS-1:0]                     m_ack_o,
    output logic [WB_DATA_WIDTH-1:0]                   m_dat_o,
    output logic                                       s_cyc_o,
    output logic                                       s_stb_o,
    output logic                                       s_we_o,
    output logic [WB_ADDR_WIDTH-1:0]                   s_adr_o,
    output logic [WB_DATA_WIDTH-1:0]                   s_dat_o,
    output logic [WB_DATA_WIDTH/8-1:0]                 s_sel_o,
    input  logic                                       s_ack_i,
    input  logic [WB_DATA_WIDTH-1:0]                   s_dat_i,
    output logic [NUM_MASTERS-1:0]                     grant_o,
    output logic                                       busy_o
);

    localparam int SW = WB_DATA_WIDTH / 8;
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state;
    logic [IW-1:0]      grant_idx;
    logic [IW-1:0]      rr_ptr;
    logic [CW-1:0]      ack_cnt;
    logic               yield0;

    logic [NUM_MASTERS-1:0] req;
    logic                   rr_found;
    logic [IW-1:0]          rr_idx;
    logic [IW:0]            cand;
    logic                   last_ack;

    assign req      = m_cyc_i & m_stb_i;
    assign last_ack = s_ack_i && (ack_cnt == CW'(MAX_BURST - 1));
    assign m_dat_o  = s_dat_i;

    // Round-robin search over 1..N-1 starting after rr_ptr; rr_ptr=0 starts at 1.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int unsigned j = 0; j < NUM_MASTERS - 1; j++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(j + 1);
            if (cand > (IW+1)'(NUM_MASTERS - 1))
                cand = cand - (IW+1)'(NUM_MASTERS - 1);
            if (!rr_found && req[cand[IW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_ack_o = '0;
        if (state == GRANT) begin
            s_cyc_o            = m_cyc_i[grant_idx];
            s_stb_o            = m_stb_i[grant_idx];
            s_we_o             = m_we_i[grant_idx];
            s_adr_o            = m_adr_i[grant_idx*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
            s_dat_o            = m_dat_i[grant_idx*WB_DATA_WIDTH +: WB_DATA_WIDTH];
            s_sel_o            = m_sel_i[grant_idx*SW +: SW];
            m_ack_o[grant_idx] = s_ack_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
            ack_cnt   <= '0;
            yield0    <= 1'b0;
            grant_o   <= '0;
            busy_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Master 0 wins unless it owes a yield and someone else is waiting.
                    if (req[0] && (!yield0 || !rr_found)) begin
                        grant_idx <= '0;
                        grant_o   <= NUM_MASTERS'(1);
                        ack_cnt   <= '0;
                        busy_o    <= 1'b1;
                        state     <= GRANT;
                    end else if (rr_found) begin
                        grant_idx <= rr_idx;
                        grant_o   <= NUM_MASTERS'(1) << rr_idx;
                        rr_ptr    <= rr_idx;
                        yield0    <= 1'b0;
                        ack_cnt   <= '0;
                        busy_o    <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!m_cyc_i[grant_idx] || last_ack) begin
                        if (last_ack && grant_idx == '0 && |req[NUM_MASTERS-1:1])
                            yield0 <= 1'b1;
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end else if (s_ack_i) begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Bench for sdram_wb_arbiter: cycle-level behavioural masters, slave and arbiter
// reference model, directed scenarios followed by a randomized soak.
module tb_sdram_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int SW = DW / 8;
    localparam int MB = 8;

    logic              wb_clk_i;
    logic              wb_rst_i;
    logic [N-1:0]      m_cyc_i, m_stb_i, m_we_i;
    logic [N*AW-1:0]   m_adr_i;
    logic [N*DW-1:0]   m_dat_i;
    logic [N*SW-1:0]   m_sel_i;
    logic [N-1:0]      m_ack_o;
    logic [DW-1:0]     m_dat_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic              s_ack_i;
    logic [DW-1:0]     s_dat_i;
    logic [N-1:0]      grant_o;
    logic              busy_o;

    sdram_wb_arbiter #(
        .NUM_MASTERS(N), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .MAX_BURST(MB)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_ack_o(m_ack_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int total = 0;
    int bad   = 0;

    // master programs
    bit            act[N];
    bit            rnd[N];
    int            rem[N], launches[N], len[N], p_launch[N];
    logic          we_q[N];
    logic [AW-1:0] adr_q[N];
    logic [DW-1:0] dat_q[N];
    logic [SW-1:0] sel_q[N];
    int            acks_obs[N], exp_acks[N];
    logic [DW-1:0] last_rd[N];

    // slave and reference state
    logic [DW-1:0] mem [int];
    int owner, last_rr, burst;
    bit yld;
    bit rst, force_ack, chk_en;
    int slv_wait, lat_max;

    int gq[$];
    int gapq[$];
    int gap;
    logic [N-1:0] prev_grant;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_txn(input int k);
        we_q[k]  = 1'($urandom_range(0, 1));
        adr_q[k] = AW'($urandom_range(0, 31));
        dat_q[k] = DW'($urandom);
        sel_q[k] = SW'($urandom_range(1, 3));
    endtask

    task automatic step();
        logic          ecyc, estb, ewe, ebusy, ack;
        logic [AW-1:0] eadr;
        logic [DW-1:0] edat, rd, old;
        logic [SW-1:0] esel;
        logic [N-1:0]  egrant, eack;
        int            pick, c, gi;
        bit            others, forced;

        for (int k = 0; k < N; k++) begin
            m_cyc_i[k]            = act[k];
            m_stb_i[k]            = act[k];
            m_we_i[k]             = we_q[k];
            m_adr_i[k*AW +: AW]   = adr_q[k];
            m_dat_i[k*DW +: DW]   = dat_q[k];
            m_sel_i[k*SW +: SW]   = sel_q[k];
        end

        ecyc = 0; estb = 0; ewe = 0; eadr = '0; edat = '0; esel = '0;
        egrant = '0; ebusy = 0;
        if (owner >= 0) begin
            ecyc = act[owner]; estb = act[owner]; ewe = we_q[owner];
            eadr = adr_q[owner]; edat = dat_q[owner]; esel = sel_q[owner];
            egrant[owner] = 1'b1; ebusy = 1'b1;
        end

        ack = 1'b0;
        if (force_ack) ack = 1'b1;
        else if (!rst && ecyc && estb) begin
            if (slv_wait == 0) begin
                ack = 1'b1;
                slv_wait = $urandom_range(0, lat_max);
            end else slv_wait--;
        end
        rd = DW'($urandom);
        if (ack && owner >= 0) begin
            old = mem.exists(int'(eadr)) ? mem[int'(eadr)] : '0;
            if (ewe) begin
                for (int b = 0; b < SW; b++)
                    if (esel[b]) old[b*8 +: 8] = edat[b*8 +: 8];
                mem[int'(eadr)] = old;
            end else rd = old;
        end
        eack = '0;
        if (owner >= 0) eack[owner] = ack;

        s_ack_i  = ack;
        s_dat_i  = rd;
        wb_rst_i = rst;
        #1;

        if (chk_en) begin
            check("grant", grant_o, egrant);
            check("busy", busy_o, ebusy);
            check("m_ack", m_ack_o, eack);
            check("s_cyc", s_cyc_o, ecyc);
            check("s_stb", s_stb_o, estb);
            check("s_we", s_we_o, ewe);
            check("s_adr", s_adr_o, eadr);
            check("s_dat", s_dat_o, edat);
            check("s_sel", s_sel_o, esel);
            check("m_dat", m_dat_o, rd);
        end

        for (int k = 0; k < N; k++)
            if (m_ack_o[k]) begin
                acks_obs[k]++;
                if (!we_q[k]) last_rd[k] = m_dat_o;
            end
        if (grant_o != '0 && prev_grant == '0) begin
            gi = -1;
            for (int k = 0; k < N; k++) if (grant_o[k]) gi = k;
            gq.push_back(gi);
            gapq.push_back(gap);
            gap = 0;
        end else if (grant_o == '0) gap++;
        prev_grant = grant_o;

        // reference arbiter: next owner from the priority/round-robin/budget rules
        others = 0;
        for (int k = 1; k < N; k++) if (act[k]) others = 1;
        if (rst) begin
            owner = -1; last_rr = 0; yld = 0; burst = 0;
        end else if (owner < 0) begin
            pick = -1;
            for (int st = 1; st < N; st++) begin
                c = ((last_rr + st - 1) % (N - 1)) + 1;
                if (pick < 0 && act[c]) pick = c;
            end
            burst = 0;
            if (act[0] && (!yld || pick < 0)) owner = 0;
            else if (pick >= 0) begin
                owner = pick; last_rr = pick; yld = 0;
            end
        end else begin
            forced = ack && (burst == MB - 1);
            if (!act[owner] || forced) begin
                if (forced && owner == 0 && others) yld = 1;
                owner = -1;
            end else if (ack) burst++;
        end

        for (int k = 0; k < N; k++) begin
            if (act[k] && eack[k]) begin
                exp_acks[k]++;
                rem[k]--;
                if (rem[k] == 0) act[k] = 0;
                else if (rnd[k]) new_txn(k);
            end else if (!act[k] && launches[k] > 0 &&
                         int'($urandom_range(1, 100)) <= p_launch[k]) begin
                act[k] = 1;
                launches[k]--;
                rem[k] = (len[k] > 0) ? len[k] : int'($urandom_range(1, 12));
                if (rnd[k]) new_txn(k);
            end
        end
        if (rst) slv_wait = 0;

        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic run_quiet(input int maxc);
        int  c;
        bit  busy;
        c = 0;
        busy = 1;
        while (busy && c < maxc) begin
            busy = (owner >= 0);
            for (int k = 0; k < N; k++) if (act[k] || launches[k] > 0) busy = 1;
            if (busy) begin
                step();
                c++;
            end
        end
        if (c >= maxc) check("timeout", 1, 0);
    endtask

    // seq holds expected master indices as nibbles, oldest first
    task automatic check_seq(input string tag, input int start, input int n,
                             input logic [31:0] seq, input bit gaps);
        int obs;
        check($sformatf("%s_count", tag), 64'(gq.size() - start), 64'(n));
        for (int i = 0; i < n; i++) begin
            obs = (gq.size() > start + i) ? gq[start + i] : 15;
            check($sformatf("%s_grant%0d", tag, i), 64'(obs), 64'(seq[4*(n-1-i) +: 4]));
            if (gaps && i > 0 && gapq.size() > start + i)
                check($sformatf("%s_gap%0d", tag, i), 64'(gapq[start + i]), 64'(1));
        end
    endtask

    initial begin
        int s, a0, a2;
        for (int k = 0; k < N; k++) begin
            act[k] = 0; rnd[k] = 1; rem[k] = 0; launches[k] = 0; len[k] = 1;
            p_launch[k] = 100; acks_obs[k] = 0; exp_acks[k] = 0; last_rd[k] = '0;
            we_q[k] = 0; adr_q[k] = '0; dat_q[k] = '0; sel_q[k] = '1;
        end
        owner = -1; last_rr = 0; yld = 0; burst = 0;
        force_ack = 0; slv_wait = 0; lat_max = 2;
        gap = 0; prev_grant = '0;

        rst = 1; chk_en = 0;
        step();
        chk_en = 1;
        step();
        check("rst_grant", grant_o, 0);
        check("rst_s_cyc", s_cyc_o, 0);
        rst = 0;

        // masters 1 and 2 alternate single reads
        len[1] = 1; len[2] = 1; launches[1] = 3; launches[2] = 3;
        s = gq.size();
        run_quiet(400);
        check_seq("rr", s, 6, 32'h121212, 1);

        // master 1 writes then reads back
        rnd[1] = 0; we_q[1] = 1; adr_q[1] = 24'h000100; dat_q[1] = 16'hA5A5; sel_q[1] = 2'b11;
        launches[1] = 1;
        s = gq.size();
        run_quiet(200);
        we_q[1] = 0; dat_q[1] = 16'h0000; last_rd[1] = '0; launches[1] = 1;
        run_quiet(200);
        check_seq("wr_rd", s, 2, 32'h11, 0);
        check("wr_rd_data", last_rd[1], 16'hA5A5);

        // master 0 beats master 2 from IDLE
        len[0] = 1; launches[0] = 1; launches[2] = 1;
        s = gq.size();
        run_quiet(200);
        check_seq("prio", s, 2, 32'h02, 1);

        // master 0 burst of 20 reads with master 1 waiting
        rnd[0] = 0; we_q[0] = 0; adr_q[0] = 24'h000010;
        len[0] = 20; launches[0] = 1; len[1] = 3; launches[1] = 1;
        a0 = acks_obs[0];
        s = gq.size();
        run_quiet(400);
        check_seq("budget", s, 4, 32'h0100, 1);
        check("budget_acks0", 64'(acks_obs[0] - a0), 20);

        // master 0 alone: forced release but immediate re-grant
        launches[0] = 1;
        a0 = acks_obs[0];
        s = gq.size();
        run_quiet(400);
        check_seq("solo0", s, 3, 32'h000, 1);
        check("solo0_acks", 64'(acks_obs[0] - a0), 20);

        // reset while master 2 waits on a slow read
        rnd[2] = 0; we_q[2] = 0; adr_q[2] = 24'h000020; len[2] = 1; launches[2] = 1;
        slv_wait = 20;
        step(); step(); step();
        check("rst_pre_grant", grant_o, 3'b100);
        rnd[1] = 0; we_q[1] = 0; len[1] = 1; launches[1] = 1;
        a2 = acks_obs[2];
        rst = 1;
        step();
        rst = 0;
        check("rst_mid_s_cyc", s_cyc_o, 0);
        check("rst_mid_grant", grant_o, 0);
        force_ack = 1;
        step();
        force_ack = 0;
        check("rst_late_ack", 64'(acks_obs[2] - a2), 0);
        s = gq.size();
        run_quiet(200);
        check_seq("post_rst", s, 2, 32'h12, 1);

        // randomized soak
        for (int k = 0; k < N; k++) begin
            rnd[k] = 1; len[k] = 0; launches[k] = 30; p_launch[k] = 25;
        end
        run_quiet(8000);
        for (int k = 0; k < N; k++)
            check($sformatf("acks_total%0d", k), 64'(acks_obs[k]), 64'(exp_acks[k]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
